// File: rtl/tdm_pkg.sv
// Shared definitions for the round-robin TDM mux/demux pair.
package tdm_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } tdm_state_e;

   localparam int TDM_DATA_WIDTH = 16;

   // Slot index width; a single channel still needs one bit.
   function automatic int slot_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Round-robin slot pointer; realign marks the current sample as slot 0.
module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter int NUM_OUTPUTS = 2,
   parameter int SLOT_W      = slot_w(NUM_OUTPUTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              realign,
   output logic [SLOT_W-1:0] slot,
   output logic              last_slot
);

   localparam logic [SLOT_W-1:0] LAST      = SLOT_W'(NUM_OUTPUTS - 1);
   localparam logic [SLOT_W-1:0] AFTER_SYN = (NUM_OUTPUTS == 1) ? '0 : SLOT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst)
         slot <= '0;
      else if (realign)
         slot <= AFTER_SYN;
      else if (advance)
         slot <= (slot == LAST) ? '0 : slot + SLOT_W'(1);
   end

   assign last_slot = (slot == LAST);

endmodule

// File: rtl/rr_tdm_demux.sv
// TDM sample demultiplexer: per-channel outputs plus a frame-aligned snapshot.
module rr_tdm_demux
   import tdm_pkg::*;
#(
   parameter int DATA_WIDTH  = TDM_DATA_WIDTH,
   parameter int NUM_OUTPUTS = 2,
   parameter int AUTO_LOCK   = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [DATA_WIDTH-1:0]                  din,
   input  logic                                   din_valid,
   input  logic                                   sync_in,
   output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] dout,
   output logic [NUM_OUTPUTS-1:0]                 dout_valid,
   output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] frame_dout,
   output logic                                   frame_valid,
   output logic                                   locked,
   output logic                                   sync_err
);

   localparam int SW = slot_w(NUM_OUTPUTS);

   tdm_state_e                             state;
   logic [SW-1:0]                          slot, wr_slot;
   logic                                   last_slot, accept, realign, frame_fire;
   logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] shadow, next_frame;

   assign realign    = din_valid & sync_in;
   assign accept     = din_valid & (sync_in | (state == LOCKED));
   assign wr_slot    = sync_in ? '0 : slot;
   // A sync write is slot 0, which only closes a frame when there is one channel.
   assign frame_fire = accept & (sync_in ? (NUM_OUTPUTS == 1) : last_slot);

   tdm_slot_counter #(.NUM_OUTPUTS(NUM_OUTPUTS), .SLOT_W(SW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .advance   (din_valid & (state == LOCKED)),
      .realign   (realign),
      .slot      (slot),
      .last_slot (last_slot)
   );

   always_comb begin
      next_frame = shadow;
      for (int i = 0; i < NUM_OUTPUTS; i++)
         if (wr_slot == SW'(i)) next_frame[i] = din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= (AUTO_LOCK != 0) ? LOCKED : UNLOCKED;
         locked      <= (AUTO_LOCK != 0);
         dout        <= '0;
         dout_valid  <= '0;
         frame_dout  <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         shadow      <= '0;
      end else begin
         dout_valid  <= '0;
         frame_valid <= 1'b0;
         sync_err    <= realign & (state == LOCKED) & (slot != '0);
         if (realign) begin
            state  <= LOCKED;
            locked <= 1'b1;
         end
         if (accept) begin
            shadow <= next_frame;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
               if (wr_slot == SW'(i)) begin
                  dout[i]       <= din;
                  dout_valid[i] <= 1'b1;
               end
            end
            if (frame_fire) begin
               frame_dout  <= next_frame;
               frame_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_tdm_demux.sv
// Randomized and directed checks of rr_tdm_demux against a channel/frame model.
module tb_rr_tdm_demux;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // two-channel instance, locks on sync
   logic [15:0]       din;
   logic              din_valid, sync_in;
   logic [1:0][15:0]  dout, frame_dout;
   logic [1:0]        dout_valid;
   logic              frame_valid, locked, sync_err;

   // single-channel instance, locked out of reset
   logic [15:0]       d1_din;
   logic              d1_valid, d1_sync;
   logic [0:0][15:0]  d1_dout, d1_frame;
   logic [0:0]        d1_dv;
   logic              d1_fv, d1_locked, d1_err;

   rr_tdm_demux #(.DATA_WIDTH(16), .NUM_OUTPUTS(2), .AUTO_LOCK(0)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync_in(sync_in),
      .dout(dout), .dout_valid(dout_valid), .frame_dout(frame_dout),
      .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err));

   rr_tdm_demux #(.DATA_WIDTH(16), .NUM_OUTPUTS(1), .AUTO_LOCK(1)) dut1 (
      .clk(clk), .rst(rst), .din(d1_din), .din_valid(d1_valid), .sync_in(d1_sync),
      .dout(d1_dout), .dout_valid(d1_dv), .frame_dout(d1_frame),
      .frame_valid(d1_fv), .locked(d1_locked), .sync_err(d1_err));

   int total = 0;
   int bad   = 0;

   // behavioural model: which channel comes next, what each channel holds,
   // and how many consecutive slots of the current rotation have been seen
   bit          m_locked;
   int          m_next, m_cnt;
   logic [15:0] m_ch[2], m_frame[2], m_part[2];
   logic [1:0]  e_dv;
   bit          e_fv, e_err;

   function automatic void model_reset();
      m_locked = 0; m_next = 0; m_cnt = 0;
      e_dv = '0; e_fv = 0; e_err = 0;
      for (int i = 0; i < 2; i++) begin m_ch[i] = '0; m_frame[i] = '0; m_part[i] = '0; end
   endfunction

   function automatic void model_step(bit v, bit s, logic [15:0] d);
      int ch;
      e_dv = '0; e_fv = 0; e_err = 0;
      if (!v) return;
      if (s) begin
         if (m_locked && m_next != 0) e_err = 1;
         ch = 0; m_locked = 1;
      end else if (!m_locked) begin
         return;
      end else begin
         ch = m_next;
      end
      m_ch[ch] = d; e_dv[ch] = 1'b1;
      if (ch == 0) m_cnt = 0;
      m_part[ch] = d; m_cnt++;
      if (ch == 1 && m_cnt == 2) begin
         m_frame[0] = m_part[0]; m_frame[1] = m_part[1]; e_fv = 1;
      end
      m_next = (ch + 1) % 2;
   endfunction

   function automatic logic [68:0] obs();
      return {dout, dout_valid, frame_dout, frame_valid, sync_err, locked};
   endfunction

   function automatic logic [68:0] expv();
      return {m_ch[1], m_ch[0], e_dv, m_frame[1], m_frame[0], e_fv, e_err, m_locked};
   endfunction

   task automatic cyc(input bit v, input bit s, input logic [15:0] d);
      din_valid = v; sync_in = s; din = d;
      model_step(v, s, d);
      @(posedge clk); #1;
      din_valid = 0; sync_in = 0;
   endtask

   task automatic test_reset();
      rst = 0; din_valid = 1; sync_in = 1; din = 16'hFFFF;
      d1_valid = 1; d1_sync = 0; d1_din = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      total++;
      if (obs() !== 69'd0) begin
         bad++; $display("FAIL reset_state got=%h want=0", obs());
      end
      total++;
      if ({d1_dout, d1_dv, d1_frame, d1_fv, d1_err, d1_locked} !== {16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL reset_single got=%h/%b locked=%b want=0/0 locked=1", d1_dout, d1_fv, d1_locked);
      end
      din_valid = 0; sync_in = 0; d1_valid = 0;
      rst = 1;
   endtask

   task automatic test_no_sync();
      logic [15:0] vals[2] = '{16'h0011, 16'h0022};
      foreach (vals[i]) begin
         cyc(1, 0, vals[i]);
         total++;
         if (obs() !== expv() || dout_valid !== 2'b00 || locked !== 1'b0) begin
            bad++; $display("FAIL no_sync[%0d] got=%h want=%h", i, obs(), expv());
         end
      end
   endtask

   task automatic test_lock_stream();
      logic [15:0] vals[4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      foreach (vals[i]) begin
         cyc(1, i == 0, vals[i]);
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL lock_stream[%0d] got=%h want=%h", i, obs(), expv());
         end
         if (i == 1 || i == 3) begin
            total++;
            if (frame_valid !== 1'b1 || frame_dout !== {vals[i], vals[i-1]}) begin
               bad++; $display("FAIL lock_frame[%0d] got=%b/%h want=1/%h", i, frame_valid, frame_dout, {vals[i], vals[i-1]});
            end
         end
      end
   endtask

   task automatic test_gaps();
      cyc(1, 0, 16'h0500);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 16'hDEAD);
         total++;
         if (obs() !== expv() || dout_valid !== 2'b00 || frame_valid !== 1'b0) begin
            bad++; $display("FAIL gap_idle[%0d] got=%h want=%h", i, obs(), expv());
         end
      end
      cyc(1, 0, 16'h0600);
      total++;
      if (frame_valid !== 1'b1 || frame_dout !== {16'h0600, 16'h0500} || dout_valid !== 2'b10) begin
         bad++; $display("FAIL gap_frame got=%b/%h want=1/06000500", frame_valid, frame_dout);
      end
   endtask

   task automatic test_realign();
      cyc(1, 0, 16'h0700);
      cyc(1, 1, 16'hAAAA);
      total++;
      if (sync_err !== 1'b1 || dout[0] !== 16'hAAAA || frame_valid !== 1'b0 || obs() !== expv()) begin
         bad++; $display("FAIL realign_sync got err=%b d0=%h fv=%b want err=1 d0=aaaa fv=0", sync_err, dout[0], frame_valid);
      end
      cyc(1, 0, 16'hBBBB);
      total++;
      if (frame_valid !== 1'b1 || frame_dout !== {16'hBBBB, 16'hAAAA} || sync_err !== 1'b0) begin
         bad++; $display("FAIL realign_frame got=%b/%h want=1/bbbbaaaa", frame_valid, frame_dout);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 16'h000C);
      rst = 0;
      @(posedge clk); #1;
      model_reset();
      total++;
      if (obs() !== 69'd0) begin
         bad++; $display("FAIL mid_reset got=%h want=0", obs());
      end
      rst = 1;
      cyc(1, 1, 16'h0005);
      cyc(1, 0, 16'h0006);
      total++;
      if (frame_valid !== 1'b1 || frame_dout !== {16'h0006, 16'h0005} || obs() !== expv()) begin
         bad++; $display("FAIL mid_reset_frame got=%b/%h want=1/00060005", frame_valid, frame_dout);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         cyc(($urandom % 4) != 0, ($urandom % 8) == 0, 16'($urandom));
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL random[%0d] got=%h want=%h", n, obs(), expv());
         end
      end
   endtask

   task automatic test_single();
      logic [15:0] vals[2] = '{16'h1234, 16'h5678};
      foreach (vals[i]) begin
         d1_valid = 1; d1_sync = 0; d1_din = vals[i];
         @(posedge clk); #1;
         total++;
         if (d1_fv !== 1'b1 || d1_frame[0] !== vals[i] || d1_dout[0] !== vals[i] || d1_dv !== 1'b1 || d1_err !== 1'b0) begin
            bad++; $display("FAIL single[%0d] got fv=%b fr=%h d=%h want fv=1 %h", i, d1_fv, d1_frame, d1_dout, vals[i]);
         end
      end
      d1_valid = 0;
      @(posedge clk); #1;
      total++;
      if (d1_fv !== 1'b0 || d1_dv !== 1'b0 || d1_frame[0] !== 16'h5678) begin
         bad++; $display("FAIL single_idle got fv=%b fr=%h want fv=0 5678", d1_fv, d1_frame);
      end
   endtask

   initial begin
      din = '0; din_valid = 0; sync_in = 0;
      d1_din = '0; d1_valid = 0; d1_sync = 0;
      model_reset();
      test_reset();
      test_no_sync();
      test_lock_stream();
      test_gaps();
      test_realign();
      test_reset_mid();
      test_random();
      test_single();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_tdm_demux.md
# rr_tdm_demux

Receive-side counterpart of the round-robin TDM mux + multiplier path. Takes one time-multiplexed sample stream, one sample per slot with channels rotating 0..NUM_OUTPUTS-1, and routes each sample back to a per-channel output register. Also presents a frame-aligned snapshot of all channels once per completed rotation. Sits directly after the DSP product output, or after the product FIFO, and feeds per-channel consumers.

## Interface
- DATA_WIDTH, 16, sample width (DSP product width).
- NUM_OUTPUTS, 2, number of TDM channels; legal range ≥1.
- AUTO_LOCK, 0, 1 = leave reset already LOCKED at slot 0; 0 = wait for sync_in.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- din  in  DATA_WIDTH  TDM sample.
- din_valid  in  1  din carries a sample this cycle.
- sync_in  in  1  qualified by din_valid; marks the current din as slot 0.
- dout  out  NUM_OUTPUTS×DATA_WIDTH  per-channel last-received sample.
- dout_valid  out  NUM_OUTPUTS  one-cycle strobe per channel on update.
- frame_dout  out  NUM_OUTPUTS×DATA_WIDTH  aligned snapshot of one complete rotation.
- frame_valid  out  1  one-cycle strobe when frame_dout updates.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle strobe: sync seen at nonzero expected slot.

## Operation
- State machine: UNLOCKED, LOCKED.
  - UNLOCKED: samples without sync_in are discarded, with no strobes. din_valid&sync_in writes slot 0, moves to LOCKED, and sets slot to 1 (or 0 if NUM_OUTPUTS=1).
  - LOCKED: each din_valid writes channel `slot`. Slot then increments, wrapping from NUM_OUTPUTS-1 to 0.
  - din_valid low: slot, state and outputs hold; strobes deassert.
- sync_in while LOCKED:
  - If slot==0: normal write, no error.
  - If slot≠0: sync_err pulses and the sample is written as slot 0. Slot realigns to 1. The partial frame is discarded: no frame_valid until a full rotation completes from the new slot 0.
- sync_in without din_valid: ignored.
- Frame capture:
  - A shadow register accumulates slots 0..NUM_OUTPUTS-2.
  - Writing slot NUM_OUTPUTS-1 copies shadow plus the current sample into frame_dout and pulses frame_valid.
  - frame_valid fires only if every slot of the rotation was written since the last slot-0 write. After lock or realign, the first frame counts from that sync.
- NUM_OUTPUTS=1: every accepted sample updates dout[0], dout_valid[0], frame_dout[0] and frame_valid.
- Data passes unmodified; no width change or sign handling.

## Timing
- Reset values:
  - dout, frame_dout: all 0.
  - dout_valid, frame_valid, sync_err: 0.
  - slot: 0.
  - locked: AUTO_LOCK.
  - State: LOCKED if AUTO_LOCK, else UNLOCKED.
- Latency: sample accepted at edge N appears on dout[ch] with dout_valid[ch]=1 in cycle N+1. Same for frame_dout/frame_valid on the last slot and for sync_err.
- locked rises in the cycle after the locking sync.
- Back-to-back valid samples sustain one sample per clock; no backpressure.
- rst low mid-rotation: on the next edge everything returns to reset values. The partial frame is lost.

## Structure
- Package tdm_pkg:
  - State enum (UNLOCKED, LOCKED).
  - SLOT_W = $clog2(NUM_OUTPUTS) with minimum 1, as a function.
  - Shared DATA_WIDTH default, for reuse by the mux side.
- Sub-module tdm_slot_counter:
  - Inputs: advance, realign.
  - Outputs: slot, last_slot flag.
  - Wraps at NUM_OUTPUTS-1 with synchronous active-low reset.
- Top: FSM, per-channel write decode, shadow/frame registers, strobes.

## Test plan
- Reset with AUTO_LOCK=0, then stream 0x0011, 0x0022 with no sync -> all dout 0, no strobes, locked=0.
- Sync with 0x0100, then 0x0200, 0x0300, 0x0400 (N=2) -> dout[0]=0x0100, dout[1]=0x0200 with strobes one cycle after each sample. frame_valid pulses after 0x0200 {0x0100,0x0200} and after 0x0400 {0x0300,0x0400}.
- Locked, din_valid gaps (valid, idle×3, valid) -> slot holds across idle. Frame completes on the second valid; no spurious strobes.
- Locked at slot 1, inject sync with 0xAAAA -> sync_err=1 next cycle, dout[0]=0xAAAA. No frame_valid until 0xBBBB arrives in slot 1, then frame {0xAAAA,0xBBBB}.
- Assert rst low after slot 0 of a frame, then sync 0x0005, 0x0006 -> outputs 0 during reset. The next frame is {0x0005,0x0006}, with no leftover data.
- NUM_OUTPUTS=1, AUTO_LOCK=1, samples 0x1234, 0x5678 -> frame_valid on both cycles; frame_dout follows din with a 1-cycle delay.
